// File: rtl/uart_tx_queue_if.sv
// Producer-side push port and transmitter-side launch/done port of the UART TX queue.
// The queue itself uses the slave view; the producer/transmitter side uses master.
interface uart_tx_queue_if #(
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          ovf;
  logic          busy;
  logic          trmt;
  logic [7:0]    tx_data;
  logic          tx_done;

  modport master (
    output wr_en, wr_data, tx_done,
    input  full, empty, count, ovf, busy, trmt, tx_data
  );

  modport slave (
    input  wr_en, wr_data, tx_done,
    output full, empty, count, ovf, busy, trmt, tx_data
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter: pops one byte per launch, pulses trmt
// for a single cycle, then waits on tx_done before launching the next byte.
module uart_tx_queue #(
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          ovf;
  logic          trmt;
  logic          trmt_nxt;
  logic [7:0]    tx_data;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // Registered full decides acceptance, so a push racing a pop on a full queue is dropped.
  assign push  = bus.wr_en && !full;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    trmt_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          trmt_nxt  = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      // tx_done may still be high from the previous byte here, so it is not looked at.
      LAUNCH: state_nxt = WAIT;
      WAIT: begin
        if (bus.tx_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      trmt    <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      state <= state_nxt;
      trmt  <= trmt_nxt;
      if (pop) begin
        tx_data <= mem[rptr];
        rptr    <= rptr + 1'b1;
      end
      if (push) wptr <= wptr + 1'b1;
      if (bus.wr_en && full) ovf <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.wr_data;
  end

  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.count   = count;
  assign bus.ovf     = ovf;
  assign bus.busy    = (state != IDLE);
  assign bus.trmt    = trmt;
  assign bus.tx_data = tx_data;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: directed scenarios plus random traffic, checked
// against a queue-based model of accepted bytes and launcher availability.
module tb_uart_tx_queue;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();
  uart_tx_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] launched[$];
  logic       m_free = 1'b1;
  logic       m_trmt = 1'b0;
  logic       m_ovf  = 1'b0;
  logic [7:0] m_tx   = 8'h00;

  logic hold = 1'b0;
  logic clr_pending = 1'b0;
  logic armed = 1'b0;
  int   tcnt = 0;
  int   turn = 5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic       wr_s, done_s, rst_s, f0, lnow, exp_next;
    logic [7:0] d_s;
    int         c0;
    wr_s = bus.wr_en; d_s = bus.wr_data; done_s = bus.tx_done; rst_s = rst;
    c0 = q.size(); f0 = m_free; lnow = m_trmt;
    @(posedge clk); #1;
    if (rst_s) begin
      q.delete(); m_free = 1'b1; m_trmt = 1'b0; m_tx = 8'h00; m_ovf = 1'b0;
    end else begin
      exp_next = f0 && (c0 > 0);
      if (wr_s) begin
        if (c0 < DEPTH) q.push_back(d_s);
        else m_ovf = 1'b1;
      end
      if (exp_next) begin
        m_tx = q.pop_front();
        m_free = 1'b0;
      end else if (!f0 && !lnow && done_s) begin
        m_free = 1'b1;
      end
      m_trmt = exp_next;
    end
    chk("trmt", 32'(bus.trmt), 32'(m_trmt));
    chk("tx_data", 32'(bus.tx_data), 32'(m_tx));
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
    chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
    chk("busy", 32'(bus.busy), 32'(!m_free));
    if (bus.trmt === 1'b1) launched.push_back(bus.tx_data);
    // Transmitter stand-in: done drops the cycle after trmt, rises after a turnaround.
    if (rst_s) begin
      bus.tx_done = 1'b0; clr_pending = 1'b0; armed = 1'b0; tcnt = 0;
    end else if (bus.trmt === 1'b1) begin
      clr_pending = 1'b1;
    end else if (clr_pending) begin
      bus.tx_done = 1'b0; clr_pending = 1'b0; tcnt = turn; armed = 1'b1;
    end else if (armed && !hold) begin
      if (tcnt > 0) tcnt--;
      else begin
        bus.tx_done = 1'b1; armed = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.wr_en = 1'b0;
    tick();
    rst = 1'b0;
    launched.delete();
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((q.size() != 0 || !m_free) && n < max) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(q.size() == 0 && m_free), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int n;
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.tx_done = 1'b0;

    // Reset and quiet period
    do_reset();
    repeat (100) tick();
    chk("t1_empty", 32'(bus.empty), 32'd1);
    chk("t1_count", 32'(bus.count), 32'd0);
    chk("t1_busy", 32'(bus.busy), 32'd0);

    // Single byte latency
    push_byte(8'hA5);
    chk("t2_trmt_c1", 32'(bus.trmt), 32'd0);
    chk("t2_count_c1", 32'(bus.count), 32'd1);
    tick();
    chk("t2_trmt_c2", 32'(bus.trmt), 32'd1);
    chk("t2_data_c2", 32'(bus.tx_data), 32'hA5);
    chk("t2_count_c2", 32'(bus.count), 32'd0);
    tick();
    chk("t2_trmt_c3", 32'(bus.trmt), 32'd0);
    wait_idle(100);
    chk("t2_busy_end", 32'(bus.busy), 32'd0);

    // Fill with transmitter stalled, then overflow
    do_reset();
    hold = 1'b1;
    for (int i = 1; i <= 10; i++) push_byte(8'(i));
    tick();
    chk("t3_full", 32'(bus.full), 32'd1);
    chk("t3_count", 32'(bus.count), 32'd8);
    chk("t3_ovf", 32'(bus.ovf), 32'd1);
    chk("t3_first", 32'(launched.size()), 32'd1);
    hold = 1'b0;
    wait_idle(300);
    chk("t3_nlaunch", 32'(launched.size()), 32'd9);
    for (int i = 0; i < 9 && i < launched.size(); i++)
      chk("t3_order", 32'(launched[i]), 32'(i + 1));

    // Pop and push coincide in IDLE
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(8'hB0 + 8'(i));
    repeat (3) tick();
    chk("t4_count_wait", 32'(bus.count), 32'd3);
    chk("t4_busy_wait", 32'(bus.busy), 32'd1);
    armed = 1'b0;
    bus.tx_done = 1'b1;
    tick();
    push_byte(8'hC4);
    chk("t4_count_same", 32'(bus.count), 32'd3);
    chk("t4_trmt", 32'(bus.trmt), 32'd1);
    chk("t4_data", 32'(bus.tx_data), 32'hB1);
    hold = 1'b0;
    wait_idle(300);
    chk("t4_nlaunch", 32'(launched.size()), 32'd5);
    if (launched.size() == 5) begin
      chk("t4_l0", 32'(launched[0]), 32'hB0);
      chk("t4_l3", 32'(launched[3]), 32'hB3);
      chk("t4_l4", 32'(launched[4]), 32'hC4);
    end

    // Paced stream of 20 bytes through the wrapping pointers
    do_reset();
    turn = 5;
    sent = 0; n = 0;
    while ((sent < 20 || q.size() != 0 || !m_free) && n < 3000) begin
      if (sent < 20 && q.size() < DEPTH && $urandom_range(0, 3) == 0) begin
        bus.wr_en = 1'b1; bus.wr_data = 8'h10 + 8'(sent); sent++;
      end else begin
        bus.wr_en = 1'b0;
      end
      tick();
      n++;
    end
    bus.wr_en = 1'b0;
    chk("t5_timeout", 32'(n < 3000), 32'd1);
    chk("t5_ovf", 32'(bus.ovf), 32'd0);
    chk("t5_nlaunch", 32'(launched.size()), 32'd20);
    for (int i = 0; i < 20 && i < launched.size(); i++)
      chk("t5_order", 32'(launched[i]), 32'h10 + 32'(i));

    // Reset while waiting with bytes queued
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'hE0 + 8'(i));
    tick();
    chk("t6_count_pre", 32'(bus.count), 32'd4);
    chk("t6_busy_pre", 32'(bus.busy), 32'd1);
    do_reset();
    hold = 1'b0;
    chk("t6_trmt", 32'(bus.trmt), 32'd0);
    chk("t6_count", 32'(bus.count), 32'd0);
    chk("t6_empty", 32'(bus.empty), 32'd1);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_ovf", 32'(bus.ovf), 32'd0);
    chk("t6_data", 32'(bus.tx_data), 32'h00);

    // Random traffic with varying turnaround and occasional overflow bursts
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      turn = $urandom_range(0, 6);
      bus.wr_en = ($urandom_range(0, 2) == 0);
      bus.wr_data = 8'($urandom);
      tick();
    end
    bus.wr_en = 1'b0;
    wait_idle(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
